// File: rtl/truth_table_sequencer.sv
// Purpose : sweeps w,x,y,z through rows 0..15, waits a settle window per row,
//           captures the function block result f_in and offers it as {row_idx,row_data}.
// Latency : first row_valid SETTLE clocks after start; row period SETTLE+1 clocks with row_ready held high.
// Backpressure: row_valid/row_idx/row_data and w,x,y,z hold while row_ready is low; sweep stalls.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, abort    begin a sweep (IDLE only) / synchronous cancel to IDLE from any state
//   w, x, y, z      stimulus; {w,x,y,z} is the current row number, w is the MSB
//   f_in            function block outputs, bit i = Fi
//   row_valid/row_ready/row_idx/row_data   captured-row output handshake
//   busy, done      busy in SETTLE/EMIT; done is a one-clock pulse after row 15 is accepted
module truth_table_sequencer #(
  parameter int SETTLE  = 12,
  parameter int NUM_OUT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               w,
  output logic               x,
  output logic               y,
  output logic               z,
  input  logic [NUM_OUT-1:0] f_in,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [3:0]         row_idx,
  output logic [NUM_OUT-1:0] row_data,
  output logic               busy,
  output logic               done
);

  // A settle window shorter than one clock is meaningless; clamp to 1.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [3:0]       idx;   // current stimulus row, drives w,x,y,z directly
  logic [CNT_W-1:0] cnt;   // clocks spent in the current settle window

  assign {w, x, y, z} = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      cnt       <= '0;
      row_valid <= 1'b0;
      row_idx   <= 4'd0;
      row_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // Abort wins over start and over a same-cycle handshake; stimulus holds.
      state     <= S_IDLE;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= 4'd0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          cnt <= cnt + 1'b1;
          // The edge that ends the window is the SETTLE-th edge after the row change.
          if (cnt == CNT_LAST) begin
            row_data  <= f_in;
            row_idx   <= idx;
            row_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            if (idx == 4'hF) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + 4'd1;
              cnt   <= '0;
              state <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          row_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

  localparam int NOUT = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            w, x, y, z;
  logic [NOUT-1:0] f_in;
  logic            row_valid;
  logic            row_ready = 1'b1;
  logic [3:0]      row_idx;
  logic [NOUT-1:0] row_data;
  logic            busy;
  logic            done;

  truth_table_sequencer #(.SETTLE(2), .NUM_OUT(NOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .f_in      (f_in),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Breadboard stand-in: rows 0 and 15 carry the known golden values.
  function automatic logic [NOUT-1:0] golden(input logic [3:0] r);
    case (r)
      4'd0:    golden = 10'h164;
      4'd15:   golden = 10'h1F6;
      default: golden = NOUT'(((int'(r) * 37) + 19) ^ 'h0A5);
    endcase
  endfunction

  logic [NOUT-1:0] pert = '0;  // disturbs f_in while a row is stalled
  assign f_in = golden({w, x, y, z}) ^ pert;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]      idx;
    logic [NOUT-1:0] data;
  } exp_t;

  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int transfers = 0, done_count = 0;
  int first_acc = 0, last_acc = 0, done_cyc = 0;
  int stall_row = -1, stall_cnt = 0;
  logic [3:0]      snap_idx;
  logic [NOUT-1:0] snap_data;

  // Consumer + scoreboard, evaluated on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (row_valid && int'(row_idx) == stall_row && stall_cnt < 5) begin
          if (stall_cnt == 0) begin
            snap_idx  = row_idx;
            snap_data = row_data;
          end else begin
            chk("hold_idx", row_idx, snap_idx);
            chk("hold_data", row_data, snap_data);
          end
          chk("hold_wxyz", {w, x, y, z}, snap_idx);
          row_ready = 1'b0;
          pert      = 10'h2AA;
          stall_cnt++;
        end else begin
          row_ready = 1'b1;
          pert      = '0;
        end
        if (row_valid && row_ready) begin
          transfers++;
          if (q.size() == 0) begin
            chk("unexpected_row", 32'(row_idx), 32'hFFFF);
          end else begin
            e = q.pop_front();
            chk("row_idx", row_idx, e.idx);
            chk("row_data", row_data, e.data);
            chk("wxyz_at_accept", {w, x, y, z}, e.idx);
            if (e.idx == 4'd0)  first_acc = cyc + 1;
            if (e.idx == 4'd15) last_acc  = cyc + 1;
          end
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
          chk("done_and_busy", busy, 0);
          chk("done_wxyz", {w, x, y, z}, 4'hF);
        end
      end
    end
  end

  task automatic push_rows();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.idx  = 4'(i);
      e.data = golden(4'(i));
      q.push_back(e);
    end
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;  // edge number on which start was sampled
  endtask

  // Full sweep; optionally checks timing and pokes start while busy and during DONE.
  task automatic do_sweep(input bit timing, input bit poke);
    int n0, d0, t0, guard;
    push_rows();
    n0 = transfers;
    d0 = done_count;
    pulse_start(t0);
    guard = 0;
    while (!done && guard < 400) begin
      if (poke) start = (guard == 10);
      @(negedge clk);
      guard++;
    end
    if (poke) start = 1'b1;  // held through the DONE cycle
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("sweep_done_pulses", done_count - d0, 1);
    chk("sweep_transfers", transfers - n0, 16);
    chk("sweep_queue_empty", q.size(), 0);
    if (timing) begin
      chk("first_accept_edge", first_acc - t0, 3);
      chk("last_accept_edge", last_acc - t0, 48);
      chk("done_cycle", done_cyc - t0, 48);
    end
    repeat (30) @(negedge clk);
    chk("idle_no_extra_rows", transfers - n0, 16);
    chk("idle_no_extra_done", done_count - d0, 1);
    chk("idle_not_busy", busy, 0);
  endtask

  initial begin
    int t0, guard, n0, d0;

    // Reset state
    #3;
    chk("rst_outputs", {row_valid, busy, done, w, x, y, z}, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_data", row_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Free-running sweep with timing and golden rows
    do_sweep(1'b1, 1'b0);

    // Backpressure on row 7
    stall_row = 7;
    stall_cnt = 0;
    do_sweep(1'b0, 1'b0);
    chk("stall_happened", stall_cnt, 5);
    stall_row = -1;

    // Abort during the settle window of row 4
    push_rows();
    n0 = transfers;
    d0 = done_count;
    pulse_start(t0);
    guard = 0;
    while (!(busy && !row_valid && {w, x, y, z} == 4'd4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reach_row4", guard < 200, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", row_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_rows_left", q.size(), 12);
    q.delete();
    repeat (20) @(negedge clk);
    chk("abort_no_more_rows", transfers - n0, 4);
    chk("abort_no_done", done_count - d0, 0);
    chk("abort_wxyz_hold", {w, x, y, z}, 4'd4);
    do_sweep(1'b0, 1'b0);

    // Asynchronous reset while row 9 is being offered
    stall_row = 9;
    stall_cnt = 0;
    push_rows();
    pulse_start(t0);
    guard = 0;
    while (!(row_valid && row_idx == 4'd9) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reset_reach_row9", guard < 200, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {row_valid, busy, done, w, x, y, z}, 0);
    chk("arst_row_idx", row_idx, 0);
    chk("arst_row_data", row_data, 0);
    chk("arst_rows_left", q.size(), 7);
    q.delete();
    repeat (3) @(negedge clk);
    stall_row = -1;
    stall_cnt = 0;
    rst_n = 1'b1;
    do_sweep(1'b0, 1'b0);

    // Start pulses while busy and during DONE are ignored
    do_sweep(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
